// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Round-robin front end that shares one fixed-latency ALU among NUM_REQ
//   requesters. The granted op is registered onto the ALU input port with a
//   one-cycle enable pulse. A tag pipeline remembers which requester owns each
//   in-flight op, and the ALU result is routed back as a registered one-hot
//   response pulse.
//
// Ports
//   clock_in, reset_in               clock, synchronous active-high reset
//   req_valid_in / req_ready_out     per-requester issue handshake
//   req_opcode_in, req_a_in, req_b_in
//                                    packed per-requester fields,
//                                    lane i at [i*W +: W]
//   alu_enable_out, alu_opcode_out,
//   alu_input1_out, alu_input2_out   registered drive to the ALU
//   alu_output_in                    ALU result, ALU_LATENCY cycles after enable
//   resp_valid_out, resp_data_out    one-hot result pulse and its data
//   busy_out                         any op issued but not yet responded
module alu_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 3,
    parameter int ALU_LATENCY  = 1
) (
    input  logic                           clock_in,
    input  logic                           reset_in,
    input  logic [NUM_REQ-1:0]             req_valid_in,
    output logic [NUM_REQ-1:0]             req_ready_out,
    input  logic [NUM_REQ*OPCODE_WIDTH-1:0] req_opcode_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b_in,
    output logic                           alu_enable_out,
    output logic [OPCODE_WIDTH-1:0]        alu_opcode_out,
    output logic [DATA_WIDTH-1:0]          alu_input1_out,
    output logic [DATA_WIDTH-1:0]          alu_input2_out,
    input  logic [DATA_WIDTH-1:0]          alu_output_in,
    output logic [NUM_REQ-1:0]             resp_valid_out,
    output logic [DATA_WIDTH-1:0]          resp_data_out,
    output logic                           busy_out
);

    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Stage 0 lines up with the enable pulse; stage STAGES lines up with a
    // valid alu_output_in.
    localparam int STAGES = ALU_LATENCY;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [DATA_WIDTH-1:0]   a;
        logic [DATA_WIDTH-1:0]   b;
    } alu_req_t;

    alu_req_t [NUM_REQ-1:0]        lane_req;
    alu_req_t                      grant_req;
    logic     [IDW-1:0]            last_grant;
    logic     [IDW-1:0]            grant_idx;
    logic                          grant_any;
    logic                          transfer;
    logic     [STAGES:0]           vld_pipe;
    logic     [STAGES:0][IDW-1:0]  tag_pipe;

    // Unpack the flat per-requester buses into one struct per lane.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lane_req[i].opcode = req_opcode_in[i*OPCODE_WIDTH +: OPCODE_WIDTH];
        assign lane_req[i].a      = req_a_in[i*DATA_WIDTH +: DATA_WIDTH];
        assign lane_req[i].b      = req_b_in[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search starting just past the last granted index. k runs
    // to NUM_REQ so the last granted requester itself is checked last.
    always_comb begin
        int idx;
        idx       = 0;
        grant_idx = last_grant;
        grant_any = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!grant_any && req_valid_in[IDW'(idx)]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
    end

    assign transfer  = grant_any && !reset_in;
    assign grant_req = lane_req[grant_idx];

    always_comb begin
        req_ready_out = '0;
        if (transfer) req_ready_out[grant_idx] = 1'b1;
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            last_grant     <= IDW'(NUM_REQ - 1);
            alu_enable_out <= 1'b0;
            alu_opcode_out <= '0;
            alu_input1_out <= '0;
            alu_input2_out <= '0;
            vld_pipe       <= '0;
            tag_pipe       <= '0;
            resp_valid_out <= '0;
            resp_data_out  <= '0;
        end else begin
            alu_enable_out <= transfer;
            if (transfer) begin
                last_grant <= grant_idx;
                {alu_opcode_out, alu_input1_out, alu_input2_out} <= grant_req;
            end
            // Tags shift unconditionally; only the valid bit gives them meaning.
            vld_pipe <= {vld_pipe[STAGES-1:0], transfer};
            tag_pipe <= {tag_pipe[STAGES-1:0], grant_idx};

            resp_valid_out <= '0;
            if (vld_pipe[STAGES]) begin
                resp_valid_out[tag_pipe[STAGES]] <= 1'b1;
                resp_data_out                    <= alu_output_in;
            end
        end
    end

    assign busy_out = alu_enable_out | (|vld_pipe) | (|resp_valid_out);

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one tensor-core ALU among NUM_REQ requesters using round-robin arbitration and a valid/ready issue handshake. It registers the granted opcode and operands onto the ALU input port and pulses the ALU enable. It tracks each in-flight operation's requester ID through a fixed-latency tag pipeline and routes the ALU result back to that requester as a registered one-cycle response.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, ALU operand/result width
OPCODE_WIDTH, 3, ALU opcode width
ALU_LATENCY, 1, clock cycles from ALU sampling enable/operands to a valid alu_output (>=1)

Ports:
clock_in  input  1  system clock
reset_in  input  1  synchronous, active-high reset
req_valid_in  input  NUM_REQ  per-requester operation valid
req_ready_out  output  NUM_REQ  per-requester grant/accept (one-hot or zero)
req_opcode_in  input  NUM_REQ*OPCODE_WIDTH  packed opcodes; requester i at [i*OPCODE_WIDTH +: OPCODE_WIDTH]
req_a_in  input  NUM_REQ*DATA_WIDTH  packed operand A, same packing
req_b_in  input  NUM_REQ*DATA_WIDTH  packed operand B, same packing
alu_enable_out  output  1  ALU enable_in, high one cycle per issued op
alu_opcode_out  output  OPCODE_WIDTH  to ALU opcode_in
alu_input1_out  output  DATA_WIDTH  to ALU alu_input1
alu_input2_out  output  DATA_WIDTH  to ALU alu_input2
alu_output_in  input  DATA_WIDTH  from ALU alu_output
resp_valid_out  output  NUM_REQ  one-hot result-valid pulse
resp_data_out  output  DATA_WIDTH  result data, valid when any resp_valid_out bit is set
busy_out  output  1  high while any op is in flight

Behaviour:
- Clock domain: the single clock is clock_in; reset_in is synchronous and active-high.
- Reset values: all outputs are 0. The round-robin pointer last_grant is set to NUM_REQ-1, so requester 0 has highest priority after reset. The tag pipeline is cleared.
- Arbitration (combinational):
  - Search starts at index last_grant+1 (mod NUM_REQ) and takes the first index with req_valid_in set.
  - req_ready_out is one-hot on that index. It is all-zero if no request is valid or reset_in is high.
  - At most one grant per cycle. The arbiter accepts a new op every cycle; there is no ALU backpressure.
  - req_ready_out may depend combinationally on req_valid_in. Requesters must not make req_valid_in depend on req_ready_out.
- Handshake: a transfer occurs in cycle n when req_valid_in[i] and req_ready_out[i] are both high.
  - Requester i must hold opcode and operands stable while valid is high and ready is low.
  - On transfer, last_grant is updated to i. Otherwise last_grant holds.
- Issue (registered): in cycle n+1, alu_enable_out=1 and alu_opcode_out/input1/input2 carry the granted fields.
  - With no transfer in cycle n, alu_enable_out=0 in cycle n+1 and the operand/opcode registers hold their previous values.
- Tag pipeline: a valid bit plus requester index (width clog2(NUM_REQ), minimum 1) enters at issue and shifts one stage per cycle, ALU_LATENCY+1 stages deep.
  - When the tag for cycle n+1+ALU_LATENCY is valid, alu_output_in is captured.
  - In cycle n+2+ALU_LATENCY, resp_valid_out[i] is high for exactly one cycle and resp_data_out holds the captured value.
- Total latency: handshake-to-response is ALU_LATENCY+2 cycles (3 with the default).
  - Back-to-back transfers yield back-to-back responses in issue order.
- resp_data_out holds its last value when no response is valid. Responses cannot be stalled.
- busy_out is the OR of the alu_enable_out register and all tag-pipeline and response valid bits.
- Boundaries:
  - A single persistent requester is granted every cycle.
  - All requesters valid: grants rotate 0,1,2,3,0,… with no requester waiting more than NUM_REQ-1 grants.
  - Pointer wrap from NUM_REQ-1 to 0 is seamless.
- Reset mid-operation: all in-flight tags and pending responses are dropped with no resp_valid_out pulse. alu_enable_out goes to 0 on the next edge. The pointer returns to NUM_REQ-1.

Test Plan:
The bench uses a behavioural ALU stub: alu_output = a+b (mod 256), registered with ALU_LATENCY=1, enabled only when enable_in is high.
1. Single request: after reset, req 2 valid with opcode 3'b000, a=3, b=4 in cycle n -> req_ready_out=4'b0100 in cycle n; alu_enable_out=1 with inputs 3/4 in cycle n+1; resp_valid_out=4'b0100 and resp_data_out=7 in cycle n+3 only.
2. Fairness: all four requesters held valid for 8 cycles, each with a=i, b=10 -> grants 0,1,2,3,0,1,2,3; responses in the same order with data 10,11,12,13 repeating, every cycle, no gaps.
3. Rotation resume: req 1 granted, then reqs 0 and 1 both valid -> req 0 granted next (pointer past 1); the next cycle req 1 is granted.
4. Wrap/overflow: req 3 a=8'hFF, b=8'h02 -> resp_data_out=8'h01 on resp_valid_out=4'b1000; the following grant with reqs 0 and 3 valid goes to 0.
5. Idle hold: no valid for 5 cycles after an op -> alu_enable_out=0; alu_input1_out/2 keep their last values; busy_out falls 0 three cycles after the last handshake.
6. Reset mid-flight: reset_in high for one cycle, one cycle after a handshake -> no resp_valid_out pulse ever appears for that op; all outputs are 0 after the edge; the first post-reset grant with all valid goes to req 0.
